imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/riscv_imm_pkg.sv | 50 +++++
 rtl/imm_gen_pipe_skid.sv | 61 ++++++
 rtl/imm_gen_pipe.sv | 57 +++++
 3 files changed

// File: rtl/riscv_imm_pkg.sv
// RISC-V immediate format selects and the combinational format decode.
// Immediates are built at 64 bits and truncated by the user to its XLEN.
package riscv_imm_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        SEL_I     = 4'd0,
        SEL_S     = 4'd1,
        SEL_U     = 4'd2,
        SEL_J     = 4'd3,
        SEL_B     = 4'd4,
        SEL_IU    = 4'd5,
        SEL_ZIMM  = 4'd6,
        SEL_SHAMT = 4'd7
    } imm_sel_e;

    // Unknown selects fall back to the I-format value.
    function automatic logic [63:0] imm_decode(input logic [31:0] inst,
                                               input logic [3:0]  sel,
                                               input logic        xlen64);
        logic [63:0] imm;
        imm = {{52{inst[31]}}, inst[31:20]};
        case (sel)
            SEL_S:     imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            SEL_U:     imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            SEL_J:     imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            SEL_B:     imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            SEL_IU:    imm = {52'b0, inst[31:20]};
            SEL_ZIMM:  imm = {59'b0, inst[19:15]};
            SEL_SHAMT: imm = xlen64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            default:   imm = {{52{inst[31]}}, inst[31:20]};
        endcase
        return imm;
    endfunction

    // A 6-bit shift amount is meaningless on a 32-bit datapath.
    function automatic logic imm_illegal(input logic [31:0] inst,
                                         input logic [3:0]  sel,
                                         input logic        xlen64);
        logic err;
        err = 1'b0;
        if (sel[3])
            err = 1'b1;
        else if (sel == SEL_SHAMT && !xlen64 && inst[25])
            err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// Output register plus one skid register; 1-cycle latency, full throughput.
// in_ready is registered and drops only while the skid slot is occupied.
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         rdy_q;
    logic         accept;
    logic         out_free;
    logic         skid_valid_nxt;

    assign accept   = in_valid && rdy_q;
    assign out_free = !out_valid || out_ready;
    assign in_ready = rdy_q;

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_free)
            skid_valid_nxt = 1'b0;
        else if (accept)
            skid_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            rdy_q      <= !skid_valid_nxt;
            if (out_free) begin
                // skid holds the older request, so it always drains first
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else begin
                    out_valid <= accept;
                    if (accept)
                        out_data <= in_data;
                end
            end else if (accept) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decodes a RISC-V immediate per request and registers it with its tag.
// 1-cycle latency, 1/cycle throughput; stalls via a 2-deep out/skid buffer.
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [3:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = XLEN + 1 + TAG_W;
    localparam logic IS64 = (XLEN == 64);

    logic [XLEN-1:0] imm_x;
    logic            err_x;
    logic [PW-1:0]   in_pay;
    logic [PW-1:0]   out_pay;

    assign imm_x  = XLEN'(imm_decode(in_inst, in_sel, IS64));
    assign err_x  = imm_illegal(in_inst, in_sel, IS64);
    assign in_pay = {imm_x, err_x, in_tag};

    imm_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {out_imm, out_err, out_tag} = out_pay;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (in_valid && in_ready && err_x && err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
    end

endmodule
